// File: rtl/apb_master_bridge_n.sv
`default_nettype none
// ============================================================================
//  Module   : apb_master_bridge_n
//  Purpose  : Bridges a valid/ready request channel onto an APB master port.
//             Requests are issued as SETUP/ACCESS transfers. A wait-cycle
//             limit ends a hung ACCESS with an error. Back-to-back requests
//             skip the IDLE cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module apb_master_bridge_n #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 8,
    parameter int NUM_SLV = 2,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [NUM_SLV-1:0] PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic              PREADY,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PSLVERR
);

    localparam int SEL_W = $clog2(NUM_SLV);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_SLV-1:0]  psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                done_ok;
    logic                done_to;
    logic                accept;
    logic [SEL_W-1:0]    sel_idx;

    // A slave answering in the last allowed cycle wins over the timeout.
    assign done_ok   = (state_q == ST_ACCESS) && PREADY;
    assign done_to   = (state_q == ST_ACCESS) && !PREADY && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign req_ready = (state_q == ST_IDLE) || done_ok || done_to;
    assign accept    = req_valid && req_ready;
    assign sel_idx   = req_addr[ADDR_W-1 -: SEL_W];

    // Next-state and next-output logic for the transfer sequencer.
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        cnt_d       = cnt_q;

        case (state_q)
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
            end
            ST_ACCESS: begin
                if (done_ok) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = PSLVERR;
                    if (!pwrite_q) begin
                        rsp_rdata_d = PRDATA;
                    end
                end else if (done_to) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (done_ok || done_to) begin
                    state_d   = ST_IDLE;
                    psel_d    = '0;
                    penable_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Acceptance overrides the return to IDLE so a held request chains
        // straight into the next SETUP.
        if (accept) begin
            state_d   = ST_SETUP;
            psel_d    = NUM_SLV'(1) << sel_idx;
            penable_d = 1'b0;
            pwrite_d  = req_write;
            paddr_d   = req_addr;
            pwdata_d  = req_wdata;
            cnt_d     = '0;
        end
    end

    // State and registered outputs, cleared asynchronously on reset.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= ST_IDLE;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            cnt_q       <= cnt_d;
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_master_bridge_n
//  Purpose  : Directed scoreboard bench for apb_master_bridge_n.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master_bridge_n;

    logic       PCLK = 1'b0;
    logic       PRESETn = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_write = 1'b0;
    logic [8:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic [1:0] PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [8:0] PADDR;
    logic [7:0] PWDATA;
    logic       PREADY = 1'b0;
    logic [7:0] PRDATA = 8'hEE;
    logic       PSLVERR = 1'b1;

    apb_master_bridge_n #(
        .ADDR_W(9), .DATA_W(8), .NUM_SLV(2), .TIMEOUT(16)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_fail = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    typedef struct {
        logic       err;
        logic [7:0] rd;
        bit         chk_rd;
        int         cyc;
    } exp_t;
    exp_t sbq[$];

    // Monitor: pop one expectation per completion pulse.
    always @(negedge PCLK) begin
        if (rsp_valid) begin
            if (sbq.size() == 0) begin
                chk("rsp_unexpected", rsp_valid, 1'b0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("rsp_err", rsp_err, e.err);
                chk("rsp_cycle", cyc, e.cyc);
                if (e.chk_rd) chk("rsp_rdata", rsp_rdata, e.rd);
            end
        end
    end

    // Slave model: garbage data/error while not ready, response after slv_wait cycles.
    int         slv_wait  = 0;
    logic [7:0] slv_rdata = 8'h00;
    logic       slv_err   = 1'b0;
    bit         slv_hang  = 1'b0;
    int         acc_n     = 0;
    always @(negedge PCLK) begin
        if (PSEL != 2'b00 && PENABLE) begin
            if (!slv_hang && acc_n == slv_wait) begin
                PREADY = 1'b1; PRDATA = slv_rdata; PSLVERR = slv_err;
            end else begin
                PREADY = 1'b0; PRDATA = 8'hEE; PSLVERR = 1'b1; acc_n++;
            end
        end else begin
            PREADY = 1'b0; PRDATA = 8'hEE; PSLVERR = 1'b1; acc_n = 0;
        end
    end

    // Called at negedge+2; returns at negedge+2 of the cycle after acceptance.
    task automatic issue(input logic w, input logic [8:0] a, input logic [7:0] d,
                         input logic e, input logic [7:0] rd, input bit chk_rd,
                         input int lat, input bit hold, input bit push);
        int n;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge PCLK); #2; n++;
        end
        chk("accept_wait", req_ready, 1'b1);
        if (push) sbq.push_back('{err: e, rd: rd, chk_rd: chk_rd, cyc: cyc + lat});
        @(negedge PCLK); #2;
        if (!hold) req_valid = 1'b0;
    endtask

    initial begin
        int n;
        // Reset values
        #3;
        chk("rst_psel", PSEL, 2'b00);
        chk("rst_penable", PENABLE, 1'b0);
        chk("rst_paddr", PADDR, 9'h000);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        repeat (2) @(negedge PCLK);
        #2 PRESETn = 1'b1;
        @(negedge PCLK); #2;
        chk("idle_ready", req_ready, 1'b1);

        // Write, immediate PREADY
        slv_wait = 0; slv_err = 0; slv_rdata = 8'h00;
        issue(1'b1, 9'h005, 8'hA5, 1'b0, 8'h00, 1'b1, 3, 1'b0, 1'b1);
        chk("wr_setup_psel", PSEL, 2'b01);
        chk("wr_setup_penable", PENABLE, 1'b0);
        chk("wr_pwrite", PWRITE, 1'b1);
        chk("wr_paddr", PADDR, 9'h005);
        chk("wr_pwdata", PWDATA, 8'hA5);
        @(negedge PCLK); #2;
        chk("wr_access_penable", PENABLE, 1'b1);
        chk("wr_access_psel", PSEL, 2'b01);
        repeat (2) @(negedge PCLK); #2;
        chk("wr_idle_psel", PSEL, 2'b00);

        // Read with two wait states
        slv_wait = 2; slv_rdata = 8'h3C;
        issue(1'b0, 9'h1F0, 8'h00, 1'b0, 8'h3C, 1'b1, 5, 1'b0, 1'b1);
        chk("rd_setup_psel", PSEL, 2'b10);
        chk("rd_pwrite", PWRITE, 1'b0);
        repeat (6) @(negedge PCLK); #2;

        // Timeout: PREADY never rises
        slv_hang = 1;
        issue(1'b0, 9'h010, 8'h00, 1'b1, 8'h00, 1'b1, 18, 1'b0, 1'b1);
        repeat (17) @(negedge PCLK); #2;
        chk("to_idle_psel", PSEL, 2'b00);
        chk("to_idle_penable", PENABLE, 1'b0);
        chk("to_idle_ready", req_ready, 1'b1);
        slv_hang = 0;

        // Slave error on write; read data stays at the previous value
        slv_wait = 1; slv_err = 1; slv_rdata = 8'h99;
        issue(1'b1, 9'h0AA, 8'h11, 1'b1, 8'h00, 1'b1, 4, 1'b0, 1'b1);
        repeat (5) @(negedge PCLK); #2;

        // Back-to-back: write then read with req_valid held
        slv_wait = 0; slv_err = 0; slv_rdata = 8'h77;
        issue(1'b1, 9'h022, 8'h5A, 1'b0, 8'h00, 1'b0, 3, 1'b1, 1'b1);
        issue(1'b0, 9'h100, 8'h00, 1'b0, 8'h77, 1'b1, 3, 1'b0, 1'b1);
        chk("b2b_setup_psel", PSEL, 2'b10);
        chk("b2b_setup_penable", PENABLE, 1'b0);
        chk("b2b_paddr", PADDR, 9'h100);
        repeat (4) @(negedge PCLK); #2;
        chk("pre_rst_rdata", rsp_rdata, 8'h77);

        // Reset in the middle of ACCESS
        slv_hang = 1;
        issue(1'b1, 9'h1FF, 8'hC3, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0);
        @(negedge PCLK); #2;
        chk("mid_access_penable", PENABLE, 1'b1);
        #1 PRESETn = 1'b0;
        #1;
        chk("arst_psel", PSEL, 2'b00);
        chk("arst_penable", PENABLE, 1'b0);
        chk("arst_pwrite", PWRITE, 1'b0);
        chk("arst_paddr", PADDR, 9'h000);
        chk("arst_pwdata", PWDATA, 8'h00);
        chk("arst_rdata", rsp_rdata, 8'h00);
        repeat (2) @(negedge PCLK);
        #2 PRESETn = 1'b1;
        slv_hang = 0; slv_wait = 0; slv_rdata = 8'h96; slv_err = 0;
        issue(1'b0, 9'h155, 8'h00, 1'b0, 8'h96, 1'b1, 3, 1'b0, 1'b1);
        chk("post_rst_psel", PSEL, 2'b10);

        // Drain the scoreboard
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge PCLK); n++;
        end
        chk("sb_drained", sbq.size(), 0);
        repeat (3) @(negedge PCLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
